// File: rtl/xv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xv (package)
//  Description : Shared types and constants for the VRAM arbitration slice.
//                vram_client_t identifies which requester owns a VRAM access
//                or a returning read word; VRAM_RD_LAT is the default read
//                latency of the VRAM macro in cycles.
//  Revision    : 1.0  initial release
// ============================================================================
package xv;

    typedef enum logic [1:0] {
        VC_NONE = 2'd0,
        VC_VID  = 2'd1,
        VC_REGS = 2'd2,
        VC_BLIT = 2'd3
    } vram_client_t;

    localparam int VRAM_RD_LAT = 1;

endpackage : xv
`default_nettype wire

// File: rtl/vram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vram_rd_tag_pipe
//  Description : RD_LAT-deep shift register of read-owner tags. A tag pushed
//                in the cycle a read strobe is on the VRAM pins emerges
//                RD_LAT cycles later, aligned with the returning read data.
//                Reset empties the pipe so no stale read is ever reported.
//  Ports       : clk      in   clock
//                reset_i  in   asynchronous active-high reset
//                tag_i    in   owner of the read issued this cycle (or NONE)
//                tag_o    out  owner of the read data arriving this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module vram_rd_tag_pipe
    import xv::*;
#(
    parameter int RD_LAT = VRAM_RD_LAT
) (
    input  logic         clk,
    input  logic         reset_i,
    input  vram_client_t tag_i,
    output vram_client_t tag_o
);

    vram_client_t stage_q [RD_LAT];

    for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
        if (s == 0) begin : g_head
            always_ff @(posedge clk or posedge reset_i) begin
                if (reset_i) begin
                    stage_q[0] <= VC_NONE;
                end else begin
                    stage_q[0] <= tag_i;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge reset_i) begin
                if (reset_i) begin
                    stage_q[s] <= VC_NONE;
                end else begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end
    end

    assign tag_o = stage_q[RD_LAT-1];

endmodule : vram_rd_tag_pipe
`default_nettype wire

// File: rtl/vram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arb
//  Description : Single-port VRAM arbiter for video fetch, register interface
//                and blitter. Video has fixed top priority; regs and blit
//                share remaining cycles round-robin. Grant is chosen
//                combinationally, the VRAM strobe and the requester ack are
//                registered one cycle later. Read owners travel down a tag
//                pipe so the returning data is flagged for the right client.
//  Ports       : clk, reset_i                    clock, async active-high reset
//                vid_req_i/vid_addr_i            video fetch strobe + address
//                vid_rd_valid_o                  read data belongs to video
//                regs_req_i/_wr_i/_addr_i/_data_i register-interface request
//                regs_ack_o, regs_rd_valid_o     issue pulse / read return
//                blit_*                          same as regs_*
//                rd_data_o                       read data from VRAM
//                vram_sel_o/_wr_o/_addr_o/_data_o VRAM access pins
//                vram_data_i                     VRAM read data
//                starve_o, starve_clr_i          sticky starvation flag / clear
//  Revision    : 1.0  initial release
// ============================================================================
module vram_arb
    import xv::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = VRAM_RD_LAT,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              reset_i,
    // video fetch
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_rd_valid_o,
    // register interface
    input  logic              regs_req_i,
    input  logic              regs_wr_i,
    input  logic [ADDR_W-1:0] regs_addr_i,
    input  logic [DATA_W-1:0] regs_data_i,
    output logic              regs_ack_o,
    output logic              regs_rd_valid_o,
    // blitter
    input  logic              blit_req_i,
    input  logic              blit_wr_i,
    input  logic [ADDR_W-1:0] blit_addr_i,
    input  logic [DATA_W-1:0] blit_data_i,
    output logic              blit_ack_o,
    output logic              blit_rd_valid_o,
    // read return
    output logic [DATA_W-1:0] rd_data_o,
    // VRAM macro
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i,
    // starvation monitor
    output logic              starve_o,
    input  logic              starve_clr_i
);

    localparam int              WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    vram_client_t      grant;
    vram_client_t      rr_q,     rr_d;
    vram_client_t      client_q, client_d;
    logic              sel_q,    sel_d;
    logic              wr_q,     wr_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              regs_ack_q, regs_ack_d;
    logic              blit_ack_q, blit_ack_d;
    logic [WAIT_W-1:0] regs_wait_q, regs_wait_d;
    logic [WAIT_W-1:0] blit_wait_q, blit_wait_d;
    logic              starve_q,   starve_d;

    vram_client_t      tag_in;
    vram_client_t      tag_out;

    // A requester's req is still high in the cycle its ack is seen, so the
    // ack itself masks that stale request from re-arbitration.
    logic regs_elig;
    logic blit_elig;

    assign regs_elig = regs_req_i && !regs_ack_q;
    assign blit_elig = blit_req_i && !blit_ack_q;

    // ------------------------------------------------------------------
    // Grant selection and round-robin pointer
    // ------------------------------------------------------------------
    always_comb begin
        grant = VC_NONE;
        if (vid_req_i) begin
            grant = VC_VID;
        end else if (regs_elig && blit_elig) begin
            grant = (rr_q == VC_BLIT) ? VC_BLIT : VC_REGS;
        end else if (regs_elig) begin
            grant = VC_REGS;
        end else if (blit_elig) begin
            grant = VC_BLIT;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant == VC_REGS) begin
            rr_d = VC_BLIT;
        end else if (grant == VC_BLIT) begin
            rr_d = VC_REGS;
        end
    end

    // ------------------------------------------------------------------
    // Access register: the granted request's fields are captured here and
    // appear on the VRAM pins next cycle. Address/data hold when idle.
    // ------------------------------------------------------------------
    always_comb begin
        sel_d      = (grant != VC_NONE);
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        client_d   = grant;
        regs_ack_d = (grant == VC_REGS);
        blit_ack_d = (grant == VC_BLIT);
        case (grant)
            VC_VID: begin
                addr_d = vid_addr_i;
            end
            VC_REGS: begin
                wr_d   = regs_wr_i;
                addr_d = regs_addr_i;
                data_d = regs_data_i;
            end
            VC_BLIT: begin
                wr_d   = blit_wr_i;
                addr_d = blit_addr_i;
                data_d = blit_data_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counters and sticky starvation flag
    // ------------------------------------------------------------------
    always_comb begin
        regs_wait_d = regs_wait_q;
        if (regs_ack_q) begin
            regs_wait_d = '0;
        end else if (regs_req_i && (grant != VC_REGS) && (regs_wait_q != WAIT_MAX)) begin
            regs_wait_d = regs_wait_q + 1'b1;
        end
    end

    always_comb begin
        blit_wait_d = blit_wait_q;
        if (blit_ack_q) begin
            blit_wait_d = '0;
        end else if (blit_req_i && (grant != VC_BLIT) && (blit_wait_q != WAIT_MAX)) begin
            blit_wait_d = blit_wait_q + 1'b1;
        end
    end

    // Set takes precedence over a simultaneous clear.
    always_comb begin
        starve_d = starve_q;
        if ((regs_wait_d >= WAIT_MAX) || (blit_wait_d >= WAIT_MAX)) begin
            starve_d = 1'b1;
        end else if (starve_clr_i) begin
            starve_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rr_q        <= VC_REGS;
            client_q    <= VC_NONE;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            regs_ack_q  <= 1'b0;
            blit_ack_q  <= 1'b0;
            regs_wait_q <= '0;
            blit_wait_q <= '0;
            starve_q    <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            client_q    <= client_d;
            sel_q       <= sel_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            regs_ack_q  <= regs_ack_d;
            blit_ack_q  <= blit_ack_d;
            regs_wait_q <= regs_wait_d;
            blit_wait_q <= blit_wait_d;
            starve_q    <= starve_d;
        end
    end

    // ------------------------------------------------------------------
    // Read-return tagging
    // ------------------------------------------------------------------
    assign tag_in = (sel_q && !wr_q) ? client_q : VC_NONE;

    vram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset_i (reset_i),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    assign vid_rd_valid_o  = (tag_out == VC_VID);
    assign regs_rd_valid_o = (tag_out == VC_REGS);
    assign blit_rd_valid_o = (tag_out == VC_BLIT);
    // Data is forced to zero outside a tagged return so the bus reads 0
    // during and after reset rather than echoing the macro's output.
    assign rd_data_o       = (tag_out != VC_NONE) ? vram_data_i : '0;

    assign vram_sel_o  = sel_q;
    assign vram_wr_o   = wr_q;
    assign vram_addr_o = addr_q;
    assign vram_data_o = data_q;
    assign regs_ack_o  = regs_ack_q;
    assign blit_ack_o  = blit_ack_q;
    assign starve_o    = starve_q;

endmodule : vram_arb
`default_nettype wire

// File: tb/tb_vram_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vram_arb
//  Description : Self-checking bench for vram_arb. One instance uses read
//                latency 1 with a behavioural VRAM; a second uses latency 3
//                and is observed around a mid-operation reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vram_arb;
    import xv::*;

    typedef struct {
        int           due;
        vram_client_t c;
        logic [15:0]  d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic        vid_req_i;
    logic [15:0] vid_addr_i;
    logic        regs_req_i, regs_wr_i;
    logic [15:0] regs_addr_i, regs_data_i;
    logic        blit_req_i, blit_wr_i;
    logic [15:0] blit_addr_i, blit_data_i;
    logic        starve_clr_i;
    logic [15:0] vram_data_i  = 16'h0000;
    logic [15:0] vram3_data_i = 16'hA5A5;

    logic        d1_vid_v, d1_regs_ack, d1_regs_v, d1_blit_ack, d1_blit_v;
    logic [15:0] d1_rd_data, d1_addr, d1_wdata;
    logic        d1_sel, d1_wr, d1_starve;
    logic        d3_vid_v, d3_regs_ack, d3_regs_v, d3_blit_ack, d3_blit_v;
    logic [15:0] d3_rd_data, d3_addr, d3_wdata;
    logic        d3_sel, d3_wr, d3_starve;

    int n_checks = 0;
    int n_fail   = 0;

    vram_arb #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_LIMIT(64)) dut (
        .clk(clk), .reset_i(reset_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_rd_valid_o(d1_vid_v),
        .regs_req_i(regs_req_i), .regs_wr_i(regs_wr_i), .regs_addr_i(regs_addr_i),
        .regs_data_i(regs_data_i), .regs_ack_o(d1_regs_ack), .regs_rd_valid_o(d1_regs_v),
        .blit_req_i(blit_req_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
        .blit_data_i(blit_data_i), .blit_ack_o(d1_blit_ack), .blit_rd_valid_o(d1_blit_v),
        .rd_data_o(d1_rd_data), .vram_sel_o(d1_sel), .vram_wr_o(d1_wr),
        .vram_addr_o(d1_addr), .vram_data_o(d1_wdata), .vram_data_i(vram_data_i),
        .starve_o(d1_starve), .starve_clr_i(starve_clr_i)
    );

    vram_arb #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .STARVE_LIMIT(64)) dut3 (
        .clk(clk), .reset_i(reset_i),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_rd_valid_o(d3_vid_v),
        .regs_req_i(regs_req_i), .regs_wr_i(regs_wr_i), .regs_addr_i(regs_addr_i),
        .regs_data_i(regs_data_i), .regs_ack_o(d3_regs_ack), .regs_rd_valid_o(d3_regs_v),
        .blit_req_i(blit_req_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
        .blit_data_i(blit_data_i), .blit_ack_o(d3_blit_ack), .blit_rd_valid_o(d3_blit_v),
        .rd_data_o(d3_rd_data), .vram_sel_o(d3_sel), .vram_wr_o(d3_wr),
        .vram_addr_o(d3_addr), .vram_data_o(d3_wdata), .vram_data_i(vram3_data_i),
        .starve_o(d3_starve), .starve_clr_i(starve_clr_i)
    );

    // Behavioural VRAM behind the latency-1 instance: unwritten words hold a
    // fixed pattern, 0x1234 holds 0xBEEF.
    logic [15:0] wmem [int];

    function automatic logic [15:0] base_word(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        if (d1_sel && !d1_wr)
            vram_data_i <= wmem.exists(int'(d1_addr)) ? wmem[int'(d1_addr)] : base_word(d1_addr);
        if (d1_sel && d1_wr)
            wmem[int'(d1_addr)] = d1_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req_i = 0; vid_addr_i = '0;
        regs_req_i = 0; regs_wr_i = 0; regs_addr_i = '0; regs_data_i = '0;
        blit_req_i = 0; blit_wr_i = 0; blit_addr_i = '0; blit_data_i = '0;
        starve_clr_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1;
        tick();
        reset_i = 0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset_i = 1;
        tick(); tick();
        n_checks++;
        if ({d1_vid_v, d1_regs_ack, d1_regs_v, d1_blit_ack, d1_blit_v, d1_rd_data,
             d1_sel, d1_wr, d1_addr, d1_wdata, d1_starve} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got sel=%b wr=%b addr=%h data=%h ack=%b%b starve=%b want all 0",
                     d1_sel, d1_wr, d1_addr, d1_wdata, d1_regs_ack, d1_blit_ack, d1_starve);
        end
        n_checks++;
        if ({d3_vid_v, d3_regs_ack, d3_regs_v, d3_blit_ack, d3_blit_v, d3_rd_data,
             d3_sel, d3_wr, d3_addr, d3_wdata, d3_starve} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat3: got sel=%b addr=%h rd=%h want all 0", d3_sel, d3_addr, d3_rd_data);
        end
        reset_i = 0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_lone_read();
        do_reset();
        regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h1234;
        tick();
        n_checks++;
        if ({d1_regs_ack, d1_sel, d1_wr, d1_addr, d1_vid_v, d1_regs_v, d1_blit_v} !==
            {1'b1, 1'b1, 1'b0, 16'h1234, 3'b000}) begin
            n_fail++;
            $display("FAIL lone_read_issue: got ack=%b sel=%b wr=%b addr=%h want ack=1 sel=1 wr=0 addr=1234",
                     d1_regs_ack, d1_sel, d1_wr, d1_addr);
        end
        regs_req_i = 0;
        tick();
        n_checks++;
        if ({d1_regs_v, d1_vid_v, d1_blit_v, d1_regs_ack, d1_sel, d1_rd_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL lone_read_return: got valid v/r/b=%b%b%b ack=%b sel=%b data=%h want 010 0 0 beef",
                     d1_vid_v, d1_regs_v, d1_blit_v, d1_regs_ack, d1_sel, d1_rd_data);
        end
        tick();
        n_checks++;
        if ({d1_vid_v, d1_regs_v, d1_blit_v} !== 3'b000) begin
            n_fail++;
            $display("FAIL lone_read_quiet: got valids=%b%b%b want 000", d1_vid_v, d1_regs_v, d1_blit_v);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_all_three();
        int n_r, n_b;
        do_reset();
        n_r = 0; n_b = 0;
        vid_req_i = 1; vid_addr_i = 16'h0100;
        regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0200;
        blit_req_i = 1; blit_wr_i = 0; blit_addr_i = 16'h0300;
        tick();
        n_checks++;
        if ({d1_sel, d1_addr, d1_regs_ack, d1_blit_ack} !== {1'b1, 16'h0100, 2'b00}) begin
            n_fail++;
            $display("FAIL all3_vid_first: got sel=%b addr=%h acks=%b%b want 1 0100 00",
                     d1_sel, d1_addr, d1_regs_ack, d1_blit_ack);
        end
        vid_req_i = 0;
        tick();
        n_r += int'(d1_regs_ack); n_b += int'(d1_blit_ack);
        n_checks++;
        if ({d1_regs_ack, d1_blit_ack, d1_addr, d1_vid_v, d1_rd_data} !==
            {2'b10, 16'h0200, 1'b1, base_word(16'h0100)}) begin
            n_fail++;
            $display("FAIL all3_regs_second: got acks=%b%b addr=%h vid_v=%b data=%h want 10 0200 1 %h",
                     d1_regs_ack, d1_blit_ack, d1_addr, d1_vid_v, d1_rd_data, base_word(16'h0100));
        end
        regs_req_i = 0;
        tick();
        n_r += int'(d1_regs_ack); n_b += int'(d1_blit_ack);
        n_checks++;
        if ({d1_regs_ack, d1_blit_ack, d1_addr, d1_regs_v, d1_rd_data} !==
            {2'b01, 16'h0300, 1'b1, base_word(16'h0200)}) begin
            n_fail++;
            $display("FAIL all3_blit_third: got acks=%b%b addr=%h regs_v=%b data=%h want 01 0300 1 %h",
                     d1_regs_ack, d1_blit_ack, d1_addr, d1_regs_v, d1_rd_data, base_word(16'h0200));
        end
        blit_req_i = 0;
        tick();
        n_r += int'(d1_regs_ack); n_b += int'(d1_blit_ack);
        n_checks++;
        if ({d1_sel, d1_blit_v, d1_rd_data} !== {1'b0, 1'b1, base_word(16'h0300)}) begin
            n_fail++;
            $display("FAIL all3_blit_return: got sel=%b blit_v=%b data=%h want 0 1 %h",
                     d1_sel, d1_blit_v, d1_rd_data, base_word(16'h0300));
        end
        tick();
        n_r += int'(d1_regs_ack); n_b += int'(d1_blit_ack);
        n_checks++;
        if (n_r !== 1 || n_b !== 1) begin
            n_fail++;
            $display("FAIL all3_ack_once: got regs_acks=%0d blit_acks=%0d want 1 1", n_r, n_b);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_vid_burst();
        int n_vid_v, n_bad;
        do_reset();
        n_vid_v = 0; n_bad = 0;
        regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0042;
        for (int i = 0; i < 10; i++) begin
            vid_req_i = 1; vid_addr_i = 16'h0400 + 16'(i);
            tick();
            n_vid_v += int'(d1_vid_v);
            if (d1_regs_ack || !d1_sel || d1_addr !== 16'h0400 + 16'(i)) n_bad++;
        end
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL vid_burst_issue: got %0d bad vid cycles want 0", n_bad);
        end
        vid_req_i = 0;
        tick();
        n_vid_v += int'(d1_vid_v);
        n_checks++;
        if ({d1_regs_ack, d1_addr} !== {1'b1, 16'h0042}) begin
            n_fail++;
            $display("FAIL vid_burst_regs_after: got ack=%b addr=%h want 1 0042", d1_regs_ack, d1_addr);
        end
        regs_req_i = 0;
        tick();
        n_vid_v += int'(d1_vid_v);
        n_checks++;
        if (n_vid_v !== 10) begin
            n_fail++;
            $display("FAIL vid_burst_reads: got %0d vid read returns want 10", n_vid_v);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_alternate();
        int n_bad;
        logic last_regs;
        do_reset();
        n_bad = 0;
        last_regs = 1'b0;
        regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0010;
        blit_req_i = 1; blit_wr_i = 0; blit_addr_i = 16'h0020;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ((d1_regs_ack ^ d1_blit_ack) !== 1'b1) n_bad++;
            else if (i == 0 && !d1_regs_ack) n_bad++;
            else if (i > 0 && d1_regs_ack === last_regs) n_bad++;
            last_regs = d1_regs_ack;
        end
        n_checks++;
        if (n_bad !== 0) begin
            n_fail++;
            $display("FAIL alternate_grants: got %0d non-alternating cycles want 0", n_bad);
        end
        idle_inputs();
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_starve();
        do_reset();
        vid_req_i = 1; vid_addr_i = 16'h0001;
        blit_req_i = 1; blit_wr_i = 0; blit_addr_i = 16'h0777;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (k == 63) begin
                n_checks++;
                if (d1_starve !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_early: got %b after 63 waits want 0", d1_starve);
                end
            end
            if (k == 64) begin
                n_checks++;
                if (d1_starve !== 1'b1) begin
                    n_fail++;
                    $display("FAIL starve_at_64: got %b want 1", d1_starve);
                end
            end
        end
        n_checks++;
        if ({d1_blit_ack, d1_starve} !== 2'b01) begin
            n_fail++;
            $display("FAIL starve_hold_70: got ack=%b starve=%b want 0 1", d1_blit_ack, d1_starve);
        end
        vid_req_i = 0;
        tick();
        n_checks++;
        if (d1_blit_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_blit_served: got ack=%b want 1", d1_blit_ack);
        end
        blit_req_i = 0;
        tick(); tick();
        n_checks++;
        if (d1_starve !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_sticky: got %b want 1", d1_starve);
        end
        starve_clr_i = 1;
        tick();
        starve_clr_i = 0;
        n_checks++;
        if (d1_starve !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_clear: got %b want 0", d1_starve);
        end
        // Second starvation with the clear landing on the setting edge.
        vid_req_i = 1; blit_req_i = 1;
        for (int k = 1; k <= 64; k++) begin
            if (k == 64) starve_clr_i = 1;
            tick();
            if (k == 63) begin
                n_checks++;
                if (d1_starve !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve2_early: got %b want 0", d1_starve);
                end
            end
        end
        starve_clr_i = 0;
        n_checks++;
        if (d1_starve !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_set_wins: got %b want 1", d1_starve);
        end
        vid_req_i = 0;
        tick();
        blit_req_i = 0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midop();
        int n_v;
        do_reset();
        regs_req_i = 1; regs_wr_i = 0; regs_addr_i = 16'h0077;
        tick();
        n_checks++;
        if ({d3_regs_ack, d3_sel, d3_wr} !== 3'b110) begin
            n_fail++;
            $display("FAIL midop_issue_lat3: got ack=%b sel=%b wr=%b want 1 1 0", d3_regs_ack, d3_sel, d3_wr);
        end
        regs_req_i = 0;
        tick();
        reset_i = 1;
        #1;
        n_checks++;
        if ({d3_vid_v, d3_regs_ack, d3_regs_v, d3_blit_ack, d3_blit_v, d3_rd_data,
             d3_sel, d3_wr, d3_addr, d3_wdata, d3_starve} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: got sel=%b addr=%h regs_v=%b rd=%h want all 0",
                     d3_sel, d3_addr, d3_regs_v, d3_rd_data);
        end
        tick();
        reset_i = 0;
        n_v = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_v += int'(d3_regs_v) + int'(d3_regs_ack);
        end
        n_checks++;
        if (n_v !== 0) begin
            n_fail++;
            $display("FAIL midop_no_stale: got %0d stale regs events want 0", n_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Random traffic against a cycle-level model of the arbitration rules
    // and a reference memory.
    task automatic test_random();
        vram_client_t m_prev, g;
        logic         rr_blit;
        logic         e_wr;
        logic [15:0]  e_addr, e_data;
        logic [15:0]  refm [int];
        exp_t         q [$];
        exp_t         e;
        vram_client_t exp_c;
        logic [15:0]  exp_d;
        logic         r_ok, b_ok;
        int           cyc;

        do_reset();
        m_prev = VC_NONE; rr_blit = 1'b0; cyc = 0;
        foreach (wmem[k]) refm[k] = wmem[k];
        for (int it = 0; it < 400; it++) begin
            // stimulus: new/withdrawn requests after ack, occasional field changes while pending
            vid_req_i  = ($urandom_range(0, 99) < 30);
            vid_addr_i = 16'($urandom_range(0, 31));
            if (!regs_req_i || m_prev == VC_REGS) begin
                regs_req_i  = ($urandom_range(0, 99) < 60);
                regs_wr_i   = $urandom_range(0, 1) == 1;
                regs_addr_i = 16'($urandom_range(0, 31));
                regs_data_i = 16'($urandom);
            end else if ($urandom_range(0, 99) < 20) begin
                regs_wr_i   = $urandom_range(0, 1) == 1;
                regs_addr_i = 16'($urandom_range(0, 31));
                regs_data_i = 16'($urandom);
            end
            if (!blit_req_i || m_prev == VC_BLIT) begin
                blit_req_i  = ($urandom_range(0, 99) < 60);
                blit_wr_i   = $urandom_range(0, 1) == 1;
                blit_addr_i = 16'($urandom_range(0, 31));
                blit_data_i = 16'($urandom);
            end else if ($urandom_range(0, 99) < 20) begin
                blit_addr_i = 16'($urandom_range(0, 31));
                blit_data_i = 16'($urandom);
            end

            // model: video first, otherwise fair alternation of unmasked requests
            r_ok = regs_req_i && (m_prev != VC_REGS);
            b_ok = blit_req_i && (m_prev != VC_BLIT);
            if (vid_req_i)          g = VC_VID;
            else if (r_ok && b_ok)  g = rr_blit ? VC_BLIT : VC_REGS;
            else if (r_ok)          g = VC_REGS;
            else if (b_ok)          g = VC_BLIT;
            else                    g = VC_NONE;
            if (g == VC_REGS) rr_blit = 1'b1;
            if (g == VC_BLIT) rr_blit = 1'b0;
            e_wr = 1'b0; e_addr = '0; e_data = '0;
            case (g)
                VC_VID:  begin e_addr = vid_addr_i; end
                VC_REGS: begin e_wr = regs_wr_i; e_addr = regs_addr_i; e_data = regs_data_i; end
                VC_BLIT: begin e_wr = blit_wr_i; e_addr = blit_addr_i; e_data = blit_data_i; end
                default: ;
            endcase
            if (g != VC_NONE) begin
                if (e_wr) begin
                    refm[int'(e_addr)] = e_data;
                end else begin
                    e.due = cyc + 1 + 1;
                    e.c   = g;
                    e.d   = refm.exists(int'(e_addr)) ? refm[int'(e_addr)] : base_word(e_addr);
                    q.push_back(e);
                end
            end

            tick();
            cyc++;

            n_checks++;
            if ({d1_sel, d1_regs_ack, d1_blit_ack} !== {g != VC_NONE, g == VC_REGS, g == VC_BLIT}) begin
                n_fail++;
                $display("FAIL rand_grant cyc%0d: got sel=%b acks=%b%b want grant=%s",
                         cyc, d1_sel, d1_regs_ack, d1_blit_ack, g.name());
            end
            if (g != VC_NONE) begin
                n_checks++;
                if (d1_wr !== e_wr || d1_addr !== e_addr || (e_wr && d1_wdata !== e_data)) begin
                    n_fail++;
                    $display("FAIL rand_access cyc%0d: got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h",
                             cyc, d1_wr, d1_addr, d1_wdata, e_wr, e_addr, e_data);
                end
            end else begin
                n_checks++;
                if (d1_wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_idle_wr cyc%0d: got wr=%b want 0", cyc, d1_wr);
                end
            end

            exp_c = VC_NONE; exp_d = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_c = e.c; exp_d = e.d;
            end
            n_checks++;
            if ({d1_vid_v, d1_regs_v, d1_blit_v} !== {exp_c == VC_VID, exp_c == VC_REGS, exp_c == VC_BLIT} ||
                (exp_c != VC_NONE && d1_rd_data !== exp_d)) begin
                n_fail++;
                $display("FAIL rand_return cyc%0d: got v/r/b=%b%b%b data=%h want %s data=%h",
                         cyc, d1_vid_v, d1_regs_v, d1_blit_v, d1_rd_data, exp_c.name(), exp_d);
            end
            m_prev = g;
        end
        idle_inputs();
        tick(); tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset_i = 1;
        test_reset();
        test_lone_read();
        test_all_three();
        test_vid_burst();
        test_alternate();
        test_starve();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vram_arb
`default_nettype wire
